// File: rtl/sys_array_stream_fetcher.sv
// sys_array_stream_fetcher
//   Latches one K x cols matrix A, streams it skewed into a weight-stationary
//   systolic array (row k delayed by k cycles), and captures the de-skewed
//   N x cols result into out_data, optionally accumulating for K-tiling.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start, cols, acc_en request; cols must be 1..M_MAX, acc_en adds into out_data
//   a_data              matrix A, element [k][m]
//   arr_in              skewed row stream to the array (registered)
//   arr_out             array result lanes, C[n][m] at cycle 1+OUT_LAT+n+m
//   out_data            result matrix C [n][m]
//   busy, done          run in progress / one-cycle completion pulse
//   out_valid           out_data holds a completed result
//   err                 one-cycle pulse for a start with illegal cols

// One output row of the array: picks arr_out[LANE] off the de-skewed schedule.
module sys_array_stream_fetcher_lane #(
  parameter int M_MAX   = 4,
  parameter int OUT_W   = 16,
  parameter int ACC_W   = 20,
  parameter int OUT_LAT = 6,
  parameter int SIGNED  = 0,
  parameter int LANE    = 0,
  parameter int CW      = 4,
  parameter int CLW     = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cap_en,
  input  logic [CW-1:0]                cyc,
  input  logic [CLW-1:0]               cols,
  input  logic                         acc_en,
  input  logic [OUT_W-1:0]             lane_in,
  output logic [M_MAX-1:0][ACC_W-1:0]  row
);
  logic [ACC_W-1:0] ext;

  if (SIGNED != 0) begin : g_sext
    assign ext = ACC_W'($signed(lane_in));
  end else begin : g_zext
    assign ext = ACC_W'(lane_in);
  end

  // Row LANE lags by LANE cycles, column m by m more; columns >= cols stay put.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row <= '0;
    end else if (cap_en) begin
      for (int m = 0; m < M_MAX; m++)
        if (m < int'(cols) && int'(cyc) == OUT_LAT + LANE + m)
          row[m] <= acc_en ? row[m] + ext : ext;
    end
  end
endmodule

module sys_array_stream_fetcher #(
  parameter int DATA_W  = 8,
  parameter int K       = 5,
  parameter int N       = 2,
  parameter int M_MAX   = 4,
  parameter int OUT_W   = 16,
  parameter int ACC_W   = 20,
  parameter int OUT_LAT = 6,
  parameter int SIGNED  = 0
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [$clog2(M_MAX+1)-1:0]             cols,
  input  logic                                   acc_en,
  input  logic [K-1:0][M_MAX-1:0][DATA_W-1:0]    a_data,
  output logic [K-1:0][DATA_W-1:0]               arr_in,
  input  logic [N-1:0][OUT_W-1:0]                arr_out,
  output logic [N-1:0][M_MAX-1:0][ACC_W-1:0]     out_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   out_valid,
  output logic                                   err
);
  localparam int CLW = $clog2(M_MAX+1);
  localparam int CW  = $clog2(OUT_LAT+N+M_MAX+1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;

  logic [K-1:0][M_MAX-1:0][DATA_W-1:0] a_reg, src;
  logic [K-1:0][DATA_W-1:0]            arr_in_d;
  logic [CLW-1:0]                      cols_reg;
  logic                                acc_reg;
  logic [CW-1:0]                       cyc;     // cycle 1+cyc of the run
  logic                                cols_ok, accept, last, run;
  int                                  cidx, ncols;

  assign cols_ok = (cols != '0) && (int'(cols) <= M_MAX);
  // The done cycle is already IDLE, so back-to-back starts need no special case.
  assign accept  = start && cols_ok && (state == IDLE);
  // Cycle L: last capture; done/out_valid show up in cycle L+1.
  assign last    = (state == RUN) && (int'(cyc) == OUT_LAT + N + int'(cols_reg) - 2);
  assign run     = (state == RUN);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (accept)    state_d = RUN;
    else if (last) state_d = IDLE;
  end

  // Next arr_in value: on acceptance the first diagonal comes straight from
  // a_data so A[0][0] appears in cycle 1; afterwards from the latched copy.
  always_comb begin
    src      = a_reg;
    cidx     = int'(cyc) + 1;
    ncols    = int'(cols_reg);
    arr_in_d = '0;
    if (accept) begin
      src   = a_data;
      cidx  = 0;
      ncols = int'(cols);
    end
    if (accept || (run && !last)) begin
      for (int k = 0; k < K; k++)
        for (int m = 0; m < M_MAX; m++)
          if (cidx == k + m && m < ncols)
            arr_in_d[k] = src[k][m];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_reg     <= '0;
      cols_reg  <= '0;
      acc_reg   <= 1'b0;
      cyc       <= '0;
      arr_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err    <= start && !cols_ok && (state == IDLE);
      done   <= last;
      busy   <= (state_d == RUN);
      arr_in <= arr_in_d;
      if (accept) begin
        a_reg     <= a_data;
        cols_reg  <= cols;
        acc_reg   <= acc_en;
        cyc       <= '0;
        out_valid <= 1'b0;
      end else if (run) begin
        cyc <= cyc + CW'(1);
      end
      if (last) out_valid <= 1'b1;
    end
  end

  for (genvar n = 0; n < N; n++) begin : g_lane
    sys_array_stream_fetcher_lane #(
      .M_MAX(M_MAX), .OUT_W(OUT_W), .ACC_W(ACC_W), .OUT_LAT(OUT_LAT),
      .SIGNED(SIGNED), .LANE(n), .CW(CW), .CLW(CLW)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .cap_en  (run),
      .cyc     (cyc),
      .cols    (cols_reg),
      .acc_en  (acc_reg),
      .lane_in (arr_out[n]),
      .row     (out_data[n])
    );
  end
endmodule

// File: tb/tb_sys_array_stream_fetcher.sv
// Bench for sys_array_stream_fetcher: a behavioural systolic array fed from
// the observed arr_in stream, plus a scoreboard of C = W x A per run.
module tb_sys_array_stream_fetcher;
  localparam int DATA_W = 8, K = 5, N = 2, M_MAX = 4, OUT_W = 16, ACC_W = 20, OUT_LAT = 6;
  localparam int CLW = $clog2(M_MAX+1);

  typedef logic [K-1:0][M_MAX-1:0][DATA_W-1:0] amat_t;
  typedef logic [N-1:0][M_MAX-1:0][ACC_W-1:0]  omat_t;
  typedef struct {
    int          done_cyc;
    logic [63:0] busy_mask;
    logic [63:0] ov_mask;
    int          arr_bad;
    int          err_cnt;
  } obs_t;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, acc_en = 1'b0;
  logic [CLW-1:0] cols = '0;
  amat_t a_data = '0;
  logic [K-1:0][DATA_W-1:0] arr_in, arr_in_s;
  logic [N-1:0][OUT_W-1:0] arr_out;
  omat_t out_data, out_data_s;
  logic busy, done, out_valid, err, busy_s, done_s, out_valid_s, err_s;

  int errors = 0, checks = 0;
  int W [N][K];
  bit ovr = 1'b0;
  logic [ACC_W-1:0] exp_u [N][M_MAX];
  logic [ACC_W-1:0] exp_s [N][M_MAX];

  always #5 clk = ~clk;

  sys_array_stream_fetcher #(.DATA_W(DATA_W), .K(K), .N(N), .M_MAX(M_MAX), .OUT_W(OUT_W),
    .ACC_W(ACC_W), .OUT_LAT(OUT_LAT), .SIGNED(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cols(cols), .acc_en(acc_en),
    .a_data(a_data), .arr_in(arr_in), .arr_out(arr_out), .out_data(out_data),
    .busy(busy), .done(done), .out_valid(out_valid), .err(err));

  sys_array_stream_fetcher #(.DATA_W(DATA_W), .K(K), .N(N), .M_MAX(M_MAX), .OUT_W(OUT_W),
    .ACC_W(ACC_W), .OUT_LAT(OUT_LAT), .SIGNED(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .cols(cols), .acc_en(acc_en),
    .a_data(a_data), .arr_in(arr_in_s), .arr_out(arr_out), .out_data(out_data_s),
    .busy(busy_s), .done(done_s), .out_valid(out_valid_s), .err(err_s));

  // Array model: A[k][m] enters row k at cycle c0+k+m, C[n][m] leaves lane n
  // at c0+OUT_LAT+n+m, so lane n now sums arr_in[k] from OUT_LAT+n-k cycles ago.
  int tcyc = 0;
  logic [K-1:0][DATA_W-1:0] hist [64];
  always @(posedge clk) tcyc <= tcyc + 1;

  function automatic logic [N-1:0][OUT_W-1:0] model_out();
    logic [N-1:0][OUT_W-1:0] r;
    int s, t;
    for (int n = 0; n < N; n++) begin
      s = 0;
      for (int k = 0; k < K; k++) begin
        t = tcyc - (OUT_LAT + n - k);
        if (t >= 1) s += W[n][k] * int'(hist[t % 64][k]);
      end
      r[n] = ovr ? {OUT_W{1'b1}} : OUT_W'(s);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    hist[tcyc % 64] <= arr_in;
    arr_out <= model_out();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic amat_t rand_a();
    amat_t a;
    for (int k = 0; k < K; k++)
      for (int m = 0; m < M_MAX; m++) a[k][m] = 8'($urandom_range(0, 255));
    return a;
  endfunction

  function automatic amat_t ones_a();
    amat_t a;
    for (int k = 0; k < K; k++)
      for (int m = 0; m < M_MAX; m++) a[k][m] = 8'd1;
    return a;
  endfunction

  task automatic set_w(input int v, input bit rnd);
    for (int n = 0; n < N; n++)
      for (int k = 0; k < K; k++) W[n][k] = rnd ? int'($urandom_range(0, 15)) : v;
  endtask

  function automatic int ref_c(input amat_t a, input int n, input int m);
    int s = 0;
    for (int k = 0; k < K; k++) s += W[n][k] * int'(a[k][m]);
    return s & 32'hFFFF;
  endfunction

  task automatic sb_clear();
    for (int n = 0; n < N; n++)
      for (int m = 0; m < M_MAX; m++) begin exp_u[n][m] = '0; exp_s[n][m] = '0; end
  endtask

  task automatic sb_apply(input amat_t a, input int c, input bit acc);
    logic [OUT_W-1:0] v;
    logic [ACC_W-1:0] eu, es;
    for (int n = 0; n < N; n++)
      for (int m = 0; m < c; m++) begin
        v  = ovr ? {OUT_W{1'b1}} : OUT_W'(ref_c(a, n, m));
        eu = ACC_W'(v);
        es = ACC_W'($signed(v));
        exp_u[n][m] = acc ? exp_u[n][m] + eu : eu;
        exp_s[n][m] = acc ? exp_s[n][m] + es : es;
      end
  endtask

  function automatic omat_t sb_pack(input bit sgn);
    omat_t r;
    for (int n = 0; n < N; n++)
      for (int m = 0; m < M_MAX; m++) r[n][m] = sgn ? exp_s[n][m] : exp_u[n][m];
    return r;
  endfunction

  function automatic omat_t fill(input logic [ACC_W-1:0] v);
    omat_t r;
    for (int n = 0; n < N; n++)
      for (int m = 0; m < M_MAX; m++) r[n][m] = v;
    return r;
  endfunction

  // Issues a start in the current cycle (cycle 0) and observes until done or
  // a cycle budget runs out; ends in the done cycle. poke>0 re-pulses start.
  task automatic drive_run(input amat_t a, input int c, input bit acc, input int poke,
                           output obs_t o);
    logic [K-1:0][DATA_W-1:0] ea;
    int idx;
    o.done_cyc = -1; o.busy_mask = '0; o.ov_mask = '0; o.arr_bad = 0; o.err_cnt = 0;
    start = 1'b1; a_data = a; cols = CLW'(c); acc_en = acc;
    tick();
    a_data = rand_a(); acc_en = ~acc;
    for (int cy = 1; cy < 48; cy++) begin
      start = (cy == poke);
      cols  = (cy == poke) ? CLW'(1) : CLW'($urandom_range(0, 7));
      o.busy_mask[cy] = busy;
      o.ov_mask[cy]   = out_valid;
      if (err) o.err_cnt++;
      for (int k = 0; k < K; k++) begin
        idx = cy - 1 - k;
        ea[k] = (idx >= 0 && idx < c) ? a[k][idx] : '0;
      end
      if (arr_in !== ea || arr_in_s !== ea) o.arr_bad++;
      if (done) begin o.done_cyc = cy; break; end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, out_valid, err, busy_s, done_s, out_valid_s, err_s} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {busy, done, out_valid, err, busy_s, done_s, out_valid_s, err_s});
    end
    checks++;
    if (arr_in !== '0 || arr_in_s !== '0 || out_data !== '0 || out_data_s !== '0) begin
      errors++;
      $display("FAIL reset_data: arr_in=%h out_data=%h out_data_s=%h expected all 0",
               arr_in, out_data, out_data_s);
    end
    reset_n = 1'b1;
    tick();
    sb_clear();
  endtask

  task automatic test_basic();
    obs_t o;
    logic [63:0] bm, om;
    bm = '0; om = '0;
    for (int i = 1; i <= 11; i++) bm[i] = 1'b1;
    om[12] = 1'b1;
    set_w(1, 1'b0);
    drive_run(ones_a(), 4, 1'b0, -1, o);
    sb_apply(ones_a(), 4, 1'b0);
    checks++;
    if (o.done_cyc !== 12) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 12", o.done_cyc); end
    checks++;
    if (o.busy_mask !== bm) begin errors++; $display("FAIL basic_busy: got %h expected %h", o.busy_mask, bm); end
    checks++;
    if (o.ov_mask !== om) begin errors++; $display("FAIL basic_out_valid: got %h expected %h", o.ov_mask, om); end
    checks++;
    if (o.arr_bad !== 0) begin errors++; $display("FAIL basic_arr_in: %0d bad cycles expected 0", o.arr_bad); end
    checks++;
    if (out_data !== fill(20'd5) || out_data_s !== fill(20'd5)) begin
      errors++; $display("FAIL basic_result: got %h / %h expected %h", out_data, out_data_s, fill(20'd5));
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [63:0] om;
    om = '0; om[12] = 1'b1;
    drive_run(ones_a(), 4, 1'b1, -1, o);
    sb_apply(ones_a(), 4, 1'b1);
    checks++;
    if (o.done_cyc !== 12) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 12", o.done_cyc); end
    checks++;
    if (o.ov_mask !== om) begin errors++; $display("FAIL b2b_out_valid: got %h expected %h", o.ov_mask, om); end
    checks++;
    if (o.arr_bad !== 0) begin errors++; $display("FAIL b2b_arr_in: %0d bad cycles expected 0", o.arr_bad); end
    checks++;
    if (out_data !== fill(20'd10) || out_data_s !== fill(20'd10)) begin
      errors++; $display("FAIL b2b_result: got %h / %h expected %h", out_data, out_data_s, fill(20'd10));
    end
    tick();
    checks++;
    if ({done, out_valid, busy} !== 3'b010) begin
      errors++; $display("FAIL b2b_after_done: done/out_valid/busy got %b expected 010", {done, out_valid, busy});
    end
  endtask

  task automatic test_cols2();
    obs_t o;
    amat_t a;
    a = rand_a();
    set_w(0, 1'b1);
    drive_run(a, 2, 1'b0, -1, o);
    sb_apply(a, 2, 1'b0);
    checks++;
    if (o.done_cyc !== 10) begin errors++; $display("FAIL cols2_done_cycle: got %0d expected 10", o.done_cyc); end
    checks++;
    if (out_data !== sb_pack(1'b0) || out_data_s !== sb_pack(1'b1)) begin
      errors++; $display("FAIL cols2_result: got %h expected %h", out_data, sb_pack(1'b0));
    end
    checks++;
    if ({out_data[0][3:2], out_data[1][3:2]} !== {4{20'd10}}) begin
      errors++; $display("FAIL cols2_untouched: got %h expected %h",
                         {out_data[0][3:2], out_data[1][3:2]}, {4{20'd10}});
    end
    checks++;
    if (o.arr_bad !== 0) begin errors++; $display("FAIL cols2_arr_in: %0d bad cycles expected 0", o.arr_bad); end
    tick();
  endtask

  task automatic test_err_ignore();
    int bad [3] = '{0, 5, 7};
    obs_t o;
    amat_t a;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; cols = CLW'(bad[i]);
      tick();
      start = 1'b0;
      checks++;
      if ({err, busy, out_valid} !== 3'b101 || out_data !== sb_pack(1'b0)) begin
        errors++; $display("FAIL err_pulse cols=%0d: err/busy/out_valid got %b expected 101, out_data %h expected %h",
                           bad[i], {err, busy, out_valid}, out_data, sb_pack(1'b0));
      end
      tick();
      checks++;
      if ({err, busy} !== 2'b00) begin
        errors++; $display("FAIL err_once cols=%0d: err/busy got %b expected 00", bad[i], {err, busy});
      end
    end
    a = rand_a();
    drive_run(a, 3, 1'b0, 4, o);
    sb_apply(a, 3, 1'b0);
    checks++;
    if (o.done_cyc !== 11 || o.err_cnt !== 0) begin
      errors++; $display("FAIL ignore_start: done cycle %0d err count %0d expected 11 and 0", o.done_cyc, o.err_cnt);
    end
    checks++;
    if (out_data !== sb_pack(1'b0)) begin
      errors++; $display("FAIL ignore_result: got %h expected %h", out_data, sb_pack(1'b0));
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: busy got %b expected 0", busy); end
  endtask

  task automatic test_random();
    obs_t o;
    amat_t a;
    int c;
    bit acc;
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 2)) tick();
      set_w(0, 1'b1);
      a = rand_a(); c = $urandom_range(1, M_MAX); acc = 1'($urandom_range(0, 1));
      drive_run(a, c, acc, -1, o);
      sb_apply(a, c, acc);
      checks++;
      if (o.done_cyc !== OUT_LAT + N + c) begin
        errors++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, o.done_cyc, OUT_LAT + N + c);
      end
      checks++;
      if (out_data !== sb_pack(1'b0)) begin
        errors++; $display("FAIL rand%0d_result: got %h expected %h", it, out_data, sb_pack(1'b0));
      end
      checks++;
      if (out_data_s !== sb_pack(1'b1)) begin
        errors++; $display("FAIL rand%0d_result_signed: got %h expected %h", it, out_data_s, sb_pack(1'b1));
      end
      checks++;
      if (o.arr_bad !== 0) begin errors++; $display("FAIL rand%0d_arr_in: %0d bad cycles expected 0", it, o.arr_bad); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    amat_t a;
    int dn = 0;
    tick();
    start = 1'b1; cols = CLW'(4); acc_en = 1'b0; a_data = rand_a();
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, out_valid, err} !== 4'b0 || arr_in !== '0 || out_data !== '0 || out_data_s !== '0) begin
      errors++; $display("FAIL midreset_outputs: ctrl=%b arr_in=%h out_data=%h expected all 0",
                         {busy, done, out_valid, err}, arr_in, out_data);
    end
    reset_n = 1'b1;
    repeat (20) begin tick(); if (done) dn++; end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d done pulses expected 0", dn); end
    sb_clear();
    set_w(0, 1'b1);
    a = rand_a();
    drive_run(a, 4, 1'b0, -1, o);
    sb_apply(a, 4, 1'b0);
    checks++;
    if (o.done_cyc !== 12 || out_data !== sb_pack(1'b0)) begin
      errors++; $display("FAIL midreset_rerun: done cycle %0d out_data %h expected 12 and %h",
                         o.done_cyc, out_data, sb_pack(1'b0));
    end
  endtask

  task automatic test_signed();
    obs_t o;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    ovr = 1'b1;
    drive_run(rand_a(), 4, 1'b1, -1, o);
    drive_run(rand_a(), 4, 1'b1, -1, o);
    checks++;
    if (out_data !== fill(20'h1FFFE)) begin
      errors++; $display("FAIL unsigned_ext: got %h expected %h", out_data, fill(20'h1FFFE));
    end
    checks++;
    if (out_data_s !== fill(20'hFFFFE)) begin
      errors++; $display("FAIL signed_ext: got %h expected %h", out_data_s, fill(20'hFFFFE));
    end
    ovr = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_cols2();
    test_err_ignore();
    test_random();
    test_reset_mid();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sys_array_stream_fetcher.md
# sys_array_stream_fetcher

Parametrised successor to the current systolic-array fetcher. It latches one input matrix A (K rows × up to M_MAX columns), streams it skewed into an external weight-stationary systolic array, and de-skews and captures the N×cols result. It adds a runtime column count, a start/busy/done handshake with an error pulse, back-to-back starts, and an optional accumulate mode for K-tiling. It sits between the host-side matrix buffers and the systolic array core.

## Interface
- DATA_W, 8, input element width
- K, 5, array input rows (shared dimension)
- N, 2, array output rows (weight rows)
- M_MAX, 4, maximum columns of A and C
- OUT_W, 16, width of each array output lane
- ACC_W, 20, result element width, ≥ OUT_W
- OUT_LAT, 6, array latency: C[n][m] appears on arr_out[n] in cycle c0+OUT_LAT+n+m, where c0 is the cycle arr_in[0] carries A[0][0]
- SIGNED, 0, 1 = sign-extend arr_out to ACC_W, 0 = zero-extend
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  request a new operation
- cols  in  $clog2(M_MAX+1)  number of active columns, valid 1..M_MAX
- acc_en  in  1  1 = add result into out_data, 0 = overwrite
- a_data  in  K×M_MAX×DATA_W  matrix A, element [k][m]
- arr_in  out  K×DATA_W  skewed row stream to the array
- arr_out  in  N×OUT_W  array result lanes
- out_data  out  N×M_MAX×ACC_W  result matrix C
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when out_data is complete
- out_valid  out  1  out_data holds a completed result
- err  out  1  one-cycle pulse when a start is rejected for an illegal cols value

## Operation
- States: IDLE, RUN.
- In IDLE, or in the done cycle, a start with 1≤cols≤M_MAX is accepted. Cycle of acceptance = cycle 0.
- On acceptance the block latches a_data, cols and acc_en, clears out_valid, moves to RUN and resets the cycle counter.
- A start with cols=0 or cols>M_MAX: err pulses the next cycle; the state and all other outputs are unchanged.
- start while busy (outside the done cycle) is ignored; no err.
- Streaming: in cycle 1+c, arr_in[k] = A[k][c−k] when 0 ≤ c−k < cols, else 0. So c0 = cycle 1.
- Capture: at the end of cycle 1+OUT_LAT+n+m, for every n<N and m<cols:
  - ext = arr_out[n] extended to ACC_W per SIGNED;
  - out_data[n][m] ← acc_en ? out_data[n][m]+ext : ext, wrapping modulo 2^ACC_W.
- Columns m ≥ cols are never written and keep their prior values.
- Last capture cycle L = OUT_LAT+N+cols−1. In cycle L+1:
  - done=1, out_valid=1, busy=0;
  - the state returns to IDLE unless a new start is accepted in that same cycle.

## Timing
- Reset values: arr_in=0, out_data=0, busy=0, done=0, out_valid=0, err=0, state IDLE.
- Reset asserted mid-operation aborts it. Every output takes its reset value at the next edge, and no done is produced.
- busy=1 from cycle 1 through cycle L. Latency start→done = OUT_LAT+N+cols cycles (12 at defaults with cols=4).
- arr_in is registered and driven only in RUN. It is 0 in IDLE and after cycle cols+K−1.
- Back-to-back: a start in the done cycle makes the next cycle 0 coincide with done. The new stream starts in the following cycle, and out_valid clears one cycle after done.
- a_data may change freely after cycle 0.
- Counter width must cover OUT_LAT+N+M_MAX without overflow.

## Test plan
- Defaults with a bench model array; A all 1, W all 1, cols=4, acc_en=0 → all eight out_data entries = 5, done pulse exactly in cycle 12, busy high in cycles 1–11.
- The same run repeated back-to-back with acc_en=1, second start issued in the done cycle → all entries = 10; second done 12 cycles after the second start; arr_in never shows the second A before cycle 1 of that run.
- cols=2 after a cols=4 run with result 5 → entries m=0,1 hold the new values, m=2,3 still 5; done in cycle 10.
- start with cols=0, then with cols=5 → err pulses once each; busy, out_valid and out_data unchanged. start pulsed in cycle 4 of an active run → ignored, done timing unchanged.
- SIGNED=1, model drives arr_out=16'hFFFF, acc_en=1 twice from zero → out_data = 20'hFFFFE; with SIGNED=0 → 20'h1FFFE.
- reset_n low in cycle 5 of a run → all outputs 0 at the next edge, no done; a fresh start after release completes normally with correct results.
